// File: rtl/router_arb_pkg.sv
// Shared types and width helpers for the router output-port arbiters.
package router_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // A single requester or a disabled watchdog still needs a 1-bit register.
  function automatic int idx_width(input int n_req);
    return (n_req > 32'sd1) ? $clog2(n_req) : 32'sd1;
  endfunction

  function automatic int cnt_width(input int max_hold);
    return (max_hold > 32'sd0) ? $clog2(max_hold + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Masked rotating priority encoder: lowest eligible request at/above ptr,
// falling back to the lowest eligible request overall.
module rr_prio_select
  import router_arb_pkg::*;
#(
  parameter int N_REQ = 16,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] upper_s;
  logic [N_REQ-1:0] pick_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // Drop the masked requester, then split the rest at the rotation pointer.
  always_comb begin
    elig_s  = '0;
    upper_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i]  = req[i] & ~(mask_en & (mask_idx == IDX_W'(i)));
      upper_s[i] = elig_s[i] & (IDX_W'(i) >= ptr);
    end
  end

  // Upper half wins when populated; otherwise the search wraps to index 0.
  always_comb begin
    pick_s = (|upper_s) ? upper_s : elig_s;
    found  = |elig_s;
    idx    = lowest_set(pick_s);
    onehot = found ? (ONE_HOT0 << idx) : '0;
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Per-output-port packet arbiter: grants one requester for a whole packet,
// round-robin or fixed priority, with a hold-time watchdog.
module rr_packet_arbiter
  import router_arb_pkg::*;
#(
  parameter  int N_REQ    = 16,
  parameter  int RR_MODE  = 1,
  parameter  int MAX_HOLD = 64,
  localparam int IDX_W    = idx_width(N_REQ),
  localparam int CNT_W    = cnt_width(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             eop,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic             WD_EN    = (MAX_HOLD != 0);

  arb_state_e       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [N_REQ-1:0] grant_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic             busy_r;
  logic             timeout_r;

  logic             in_hold_s;
  logic             eop_hit_s;
  logic             withdraw_s;
  logic             wd_hit_s;
  logic             release_s;
  logic [IDX_W-1:0] ptr_next_s;
  logic [N_REQ-1:0] sel_onehot_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;

  // While holding, the current grantee is excluded so a released requester
  // cannot win the very next selection.
  rr_prio_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_select (
    .req      (req),
    .ptr      (ptr_r),
    .mask_idx (grant_idx_r),
    .mask_en  (in_hold_s),
    .onehot   (sel_onehot_s),
    .idx      (sel_idx_s),
    .found    (sel_found_s)
  );

  // Release conditions and the rotation point after a fresh grant.
  always_comb begin
    in_hold_s  = (state_r == HOLD);
    eop_hit_s  = in_hold_s & eop;
    withdraw_s = in_hold_s & ~req[grant_idx_r];
    wd_hit_s   = in_hold_s & WD_EN & (hold_cnt_r == CNT_LAST);
    release_s  = eop_hit_s | withdraw_s | wd_hit_s;
    if (RR_MODE != 0) begin
      ptr_next_s = (sel_idx_s == IDX_LAST) ? '0 : (sel_idx_s + IDX_W'(1'b1));
    end else begin
      ptr_next_s = '0;
    end
  end

  // Packet-hold FSM with registered grant, index, busy and timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      hold_cnt_r  <= '0;
      grant_r     <= '0;
      grant_idx_r <= '0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sel_found_s) begin
            state_r     <= HOLD;
            grant_r     <= sel_onehot_s;
            grant_idx_r <= sel_idx_s;
            busy_r      <= 1'b1;
            hold_cnt_r  <= '0;
            ptr_r       <= ptr_next_s;
          end else begin
            state_r     <= IDLE;
            grant_r     <= '0;
            grant_idx_r <= '0;
            busy_r      <= 1'b0;
            hold_cnt_r  <= '0;
          end
        end
        HOLD: begin
          if (release_s) begin
            // Only a pure watchdog release is flagged.
            timeout_r <= wd_hit_s & ~eop_hit_s & ~withdraw_s;
            if (sel_found_s) begin
              state_r     <= HOLD;
              grant_r     <= sel_onehot_s;
              grant_idx_r <= sel_idx_s;
              busy_r      <= 1'b1;
              hold_cnt_r  <= '0;
              ptr_r       <= ptr_next_s;
            end else begin
              state_r     <= IDLE;
              grant_r     <= '0;
              grant_idx_r <= '0;
              busy_r      <= 1'b0;
              hold_cnt_r  <= '0;
            end
          end else if (hold_cnt_r != CNT_SAT) begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1'b1);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_r     <= '0;
          grant_idx_r <= '0;
          busy_r      <= 1'b0;
          hold_cnt_r  <= '0;
          ptr_r       <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_r;
  assign grant_idx = grant_idx_r;
  assign busy      = busy_r;
  assign timeout   = timeout_r;

endmodule
